bpred_mem: RTL and testbench
============================

BPRED_MEM -- requirements
Module: bpred_mem

Interface
REQ-001 Parameter DEPTH, default 256: number of words in each memory array.
REQ-002 Parameter AW, default 8: address width, log2(DEPTH).
REQ-003 Port clk  input  1: rising-edge clock for all state.
REQ-004 Port reset  input  1: reset, synchronous, active-high; clock clk.
REQ-005 Port insn_wren  input  1: instruction-memory write enable.
REQ-006 Port insn_wraddress  input  AW: instruction-memory write address.
REQ-007 Port insn_data  input  32: instruction-memory write data.
REQ-008 Port insn_rdaddress  input  AW: instruction-memory read address (fetch PC[9:2]).
REQ-009 Port insn_q  output  32: instruction-memory read data.
REQ-010 Port btb_wren  input  1: BTB/bimodal write enable.
REQ-011 Port btb_byteena  input  4: per-lane write enable, lane k = bits [9k+8:9k].
REQ-012 Port btb_wraddress  input  AW: BTB write address.
REQ-013 Port btb_data  input  36: BTB write data, {target[31:2], counter[1:0], carry[3:0]} packing, opaque to this block.
REQ-014 Port btb_rdaddress  input  AW: BTB read address (bimodal index).
REQ-015 Port btb_q  output  36: BTB read data.

Function
REQ-016 Two independent simple-dual-port arrays: INSN is DEPTH x 32, BTB is DEPTH x 36; one read port and one write port each, both usable in the same cycle.
REQ-017 INSN write: on a rising edge with insn_wren=1 and reset=0, the word at insn_wraddress becomes insn_data.
REQ-018 BTB write: on a rising edge with btb_wren=1, for each k with btb_byteena[k]=1, bits [9k+8:9k] at btb_wraddress take btb_data[9k+8:9k]; lanes with btb_byteena[k]=0 keep their contents.
REQ-019 btb_byteena=4'b0000 with btb_wren=1 leaves the array unchanged.
REQ-020 BTB writes are accepted during reset, so the parent can sweep-initialize counters under reset.
REQ-021 Read latency is 1 cycle: the address sampled on edge N gives its data on the q output from edge N until edge N+1; q is registered with no output register stage.
REQ-022 Read-during-write to the same address on the same edge returns the OLD word, per lane for BTB.
REQ-023 Writes and reads at different addresses on the same edge do not interact.
REQ-024 Addresses are exactly AW bits wide and are not wrapped or range-checked beyond that width.
REQ-025 Initial contents of both arrays are all zero at time 0, with no X.
REQ-026 q outputs hold their value when the read address is unchanged, and re-read the array every cycle.

Reset
REQ-027 While reset=1, insn_q and btb_q are driven to 0 on the next rising edge and held at 0.
REQ-028 Reset does not clear array contents.
REQ-029 Reset blocks INSN writes.
REQ-030 On the first edge after reset deasserts, normal reads resume with 1-cycle latency.

Structure
REQ-031 A shared package holds DEPTH/AW defaults, the widths INSN_W=32, BTB_W=36, LANE_W=9, NLANES=4, and a 36-bit BTB word struct {tgt[29:0], ctr[1:0], carry[3:0]}.
REQ-032 One sub-module is natural: sdp_ram (parameterized width, lanes, depth, byte-enable), instantiated twice; INSN uses a single 32-bit lane with enable tied to insn_wren.
REQ-033 Arrays are inferable as block RAM: no asynchronous reads and no reset on storage.

Verification
REQ-034 Write insn 0x0000_0026 at addr 5, then read addr 5 -> insn_q=0x0000_0026 exactly one edge after the address is sampled.
REQ-035 Write btb 0xF_FFFF_FFFF byteena 4'hF at addr 3, then write 0x0_0000_0155 byteena 4'h1 at addr 3 -> read gives 0xF_FFFF_FF55 (only lane 0 replaced).
REQ-036 Same edge: write btb addr 7 = 0x1_2345_6789 while reading addr 7 holding 0 -> btb_q=0 that cycle and 0x1_2345_6789 the next.
REQ-037 reset=1 for 3 cycles while writing btb addr 0..2 with byteena 4'h1 and data 0 -> btb_q=0 and insn_q=0 during reset; lanes 1-3 of addr 0..2 are unchanged afterward; an insn write issued during reset has no effect.
REQ-038 Back-to-back reads of addr 255 then 0 after writes 0xDEAD_BEEF and 0x0000_0001 -> insn_q shows 0xDEAD_BEEF then 0x0000_0001 on consecutive cycles.

Source files
------------

// File: rtl/bpred_mem_pkg.sv
// Shared widths and defaults for the branch-predictor instruction/BTB memories.
package bpred_mem_pkg;

    localparam int DEPTH_DEF = 256;
    localparam int AW_DEF    = 8;

    localparam int INSN_W = 32;
    localparam int BTB_W  = 36;
    localparam int LANE_W = 9;
    localparam int NLANES = 4;

    typedef struct packed {
        logic [29:0] tgt;
        logic [1:0]  ctr;
        logic [3:0]  carry;
    } btb_word_t;

endpackage

// File: rtl/bpred_mem_sdp_ram.sv
// Simple-dual-port RAM with per-lane write enables and a registered read port.
module bpred_mem_sdp_ram #(
    parameter int LANE_W = 9,
    parameter int NLANES = 4,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wren,
    input  logic [NLANES-1:0]        i_byteena,
    input  logic [AW-1:0]            i_wraddress,
    input  logic [LANE_W*NLANES-1:0] i_data,
    input  logic [AW-1:0]            i_rdaddress,
    output logic [LANE_W*NLANES-1:0] o_q
);

    localparam int W = LANE_W * NLANES;

    // Storage has no reset so it maps onto block RAM; contents start at zero.
    logic [W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NLANES; k++) begin
            if (i_wren && i_byteena[k]) begin
                r_mem[i_wraddress][k*LANE_W +: LANE_W] <= i_data[k*LANE_W +: LANE_W];
            end
        end
    end

    // Read samples the pre-write word, so a same-address write shows up a cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_mem[i_rdaddress];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bpred_mem.sv
// Instruction memory and BTB/bimodal table for the fetch-stage branch predictor.
module bpred_mem
    import bpred_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     insn_wren,
    input  logic [AW-1:0]            insn_wraddress,
    input  logic [INSN_W-1:0]        insn_data,
    input  logic [AW-1:0]            insn_rdaddress,
    output logic [INSN_W-1:0]        insn_q,
    input  logic                     btb_wren,
    input  logic [NLANES-1:0]        btb_byteena,
    input  logic [AW-1:0]            btb_wraddress,
    input  logic [BTB_W-1:0]         btb_data,
    input  logic [AW-1:0]            btb_rdaddress,
    output logic [BTB_W-1:0]         btb_q
);

    // Instruction writes are held off during reset; BTB writes are not, so the
    // parent can sweep counters while reset is asserted.
    logic w_insn_we;
    assign w_insn_we = insn_wren & ~reset;

    bpred_mem_sdp_ram #(
        .LANE_W (INSN_W),
        .NLANES (1),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_insn (
        .clk         (clk),
        .reset       (reset),
        .i_wren      (w_insn_we),
        .i_byteena   (w_insn_we),
        .i_wraddress (insn_wraddress),
        .i_data      (insn_data),
        .i_rdaddress (insn_rdaddress),
        .o_q         (insn_q)
    );

    bpred_mem_sdp_ram #(
        .LANE_W (LANE_W),
        .NLANES (NLANES),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .i_wren      (btb_wren),
        .i_byteena   (btb_byteena),
        .i_wraddress (btb_wraddress),
        .i_data      (btb_data),
        .i_rdaddress (btb_rdaddress),
        .o_q         (btb_q)
    );

endmodule

// File: tb/tb_bpred_mem.sv
// Randomized bench for bpred_mem against an array-based reference model.
module tb_bpred_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        insn_wren;
    logic [7:0]  insn_wraddress;
    logic [31:0] insn_data;
    logic [7:0]  insn_rdaddress;
    logic [31:0] insn_q;
    logic        btb_wren;
    logic [3:0]  btb_byteena;
    logic [7:0]  btb_wraddress;
    logic [35:0] btb_data;
    logic [7:0]  btb_rdaddress;
    logic [35:0] btb_q;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_insn [256];
    logic [35:0] m_btb  [256];
    logic [35:0] saved  [3];

    always #5 clk = ~clk;

    bpred_mem dut (
        .clk            (clk),
        .reset          (reset),
        .insn_wren      (insn_wren),
        .insn_wraddress (insn_wraddress),
        .insn_data      (insn_data),
        .insn_rdaddress (insn_rdaddress),
        .insn_q         (insn_q),
        .btb_wren       (btb_wren),
        .btb_byteena    (btb_byteena),
        .btb_wraddress  (btb_wraddress),
        .btb_data       (btb_data),
        .btb_rdaddress  (btb_rdaddress),
        .btb_q          (btb_q)
    );

    task automatic chk_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model predicts q from the current inputs, applies writes, then compares.
    task automatic tick();
        logic [31:0] exp_i;
        logic [35:0] exp_b;
        exp_i = reset ? 32'h0 : m_insn[insn_rdaddress];
        exp_b = reset ? 36'h0 : m_btb[btb_rdaddress];
        if (insn_wren && !reset) m_insn[insn_wraddress] = insn_data;
        if (btb_wren) begin
            for (int k = 0; k < 4; k++) begin
                if (btb_byteena[k]) m_btb[btb_wraddress][k*9 +: 9] = btb_data[k*9 +: 9];
            end
        end
        @(posedge clk);
        #1;
        chk_eq("insn_q", {4'h0, insn_q}, {4'h0, exp_i});
        chk_eq("btb_q", btb_q, exp_b);
        insn_wren = 1'b0;
        btb_wren  = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            m_insn[a] = '0;
            m_btb[a]  = '0;
        end
        reset = 1'b1;
        insn_wren = 0; insn_wraddress = 0; insn_data = 0; insn_rdaddress = 0;
        btb_wren = 0; btb_byteena = 0; btb_wraddress = 0; btb_data = 0; btb_rdaddress = 0;

        tick(); tick();
        chk_eq("reset_btb_q", btb_q, 36'h0);
        reset = 1'b0;

        // Untouched memory reads as zero.
        insn_rdaddress = 8'd5; btb_rdaddress = 8'd200;
        tick();
        chk_eq("init_zero_insn", {4'h0, insn_q}, 36'h0);

        // Instruction write then read.
        insn_wren = 1; insn_wraddress = 8'd5; insn_data = 32'h0000_0026; insn_rdaddress = 8'd0;
        tick();
        insn_rdaddress = 8'd5;
        tick();
        chk_eq("insn_rd5", {4'h0, insn_q}, 36'h0_0000_0026);

        // Partial-lane BTB update.
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'd3; btb_data = 36'hF_FFFF_FFFF;
        tick();
        btb_wren = 1; btb_byteena = 4'h1; btb_wraddress = 8'd3; btb_data = 36'h0_0000_0155;
        tick();
        btb_rdaddress = 8'd3;
        tick();
        chk_eq("btb_lane0", btb_q, 36'hF_FFFF_FF55);

        // Zero byte-enable leaves the word alone.
        btb_wren = 1; btb_byteena = 4'h0; btb_wraddress = 8'd3; btb_data = 36'h0;
        tick();
        tick();
        chk_eq("btb_be0", btb_q, 36'hF_FFFF_FF55);

        // Read-during-write returns the old word.
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'd7; btb_data = 36'h1_2345_6789;
        btb_rdaddress = 8'd7;
        tick();
        chk_eq("rdw_old", btb_q, 36'h0);
        tick();
        chk_eq("rdw_new", btb_q, 36'h1_2345_6789);

        // Prefill, then sweep lane 0 under reset while attempting an insn write.
        for (int a = 0; a < 3; a++) begin
            saved[a] = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'(a); btb_data = saved[a];
            tick();
        end
        insn_wren = 1; insn_wraddress = 8'd10; insn_data = 32'hAAAA_5555;
        tick();
        reset = 1'b1;
        for (int a = 0; a < 3; a++) begin
            btb_wren = 1; btb_byteena = 4'h1; btb_wraddress = 8'(a); btb_data = 36'h0;
            insn_wren = 1; insn_wraddress = 8'd10; insn_data = 32'h0000_1234;
            insn_rdaddress = 8'd10; btb_rdaddress = 8'd3;
            tick();
            chk_eq("rst_insn_q", {4'h0, insn_q}, 36'h0);
            chk_eq("rst_btb_q", btb_q, 36'h0);
        end
        reset = 1'b0;
        insn_rdaddress = 8'd10;
        for (int a = 0; a < 3; a++) begin
            btb_rdaddress = 8'(a);
            tick();
            chk_eq("sweep_keep", btb_q, {saved[a][35:9], 9'h0});
        end
        chk_eq("rst_insn_blk", {4'h0, insn_q}, 36'h0_AAAA_5555);

        // Back-to-back reads at the address extremes.
        insn_wren = 1; insn_wraddress = 8'd255; insn_data = 32'hDEAD_BEEF;
        tick();
        insn_wren = 1; insn_wraddress = 8'd0; insn_data = 32'h0000_0001;
        tick();
        insn_rdaddress = 8'd255;
        tick();
        chk_eq("b2b_255", {4'h0, insn_q}, 36'h0_DEAD_BEEF);
        insn_rdaddress = 8'd0;
        tick();
        chk_eq("b2b_0", {4'h0, insn_q}, 36'h0_0000_0001);

        // Random traffic, mostly on a small address window to force collisions.
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 29) == 0);
            insn_wren      = $urandom_range(0, 1);
            insn_wraddress = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            insn_data      = $urandom;
            insn_rdaddress = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            btb_wren       = $urandom_range(0, 1);
            btb_byteena    = 4'($urandom);
            btb_wraddress  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            btb_data       = {4'($urandom), 32'($urandom)};
            btb_rdaddress  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
